// File: rtl/cfg_chain_shifter_if.sv
// Word-stream handshake between the bitstream decryptor and cfg_chain_shifter.
//   word_i        : bitstream word, bit WORD_W-1 is shifted onto the chain first
//   word_valid_i  : word_i carries a valid word
//   word_ready_o  : the shifter accepts word_i in this cycle
// The master modport is the word source; the slave modport is the shifter.
interface cfg_chain_shifter_if #(
    parameter int WORD_W = 32
);
    logic [WORD_W-1:0] word_i;
    logic              word_valid_i;
    logic              word_ready_o;

    modport master (
        output word_i,
        output word_valid_i,
        input  word_ready_o
    );

    modport slave (
        input  word_i,
        input  word_valid_i,
        output word_ready_o
    );
endinterface

// File: rtl/cfg_chain_shifter.sv
// Serialising configuration loader for the FPGA fabric.
// Sequences pReset/fabric reset, then shifts exactly CHAIN_LEN bits MSB-first
// onto the configuration-chain head with a per-bit programming-clock enable.
// Ports:
//   clk           : single clock, rising edge
//   reset_n       : asynchronous active-low reset
//   start_i       : one-cycle load request, honoured in IDLE or DONE only
//   word_bus      : word stream (word_i / word_valid_i in, word_ready_o out)
//   ccff_head_o   : serial data to the chain head (registered)
//   prog_clk_en_o : programming-clock enable, high only with a valid bit
//   pReset_o      : programming reset, high from RESET entry until DONE
//   fpga_rst_o    : fabric reset, high from RESET entry until DONE
//   busy_o        : high in RESET, LOAD and SHIFT
//   done_o        : high in DONE
module cfg_chain_shifter #(
    parameter int CHAIN_LEN     = 2281,
    parameter int WORD_W        = 32,
    parameter int PRESET_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start_i,
    cfg_chain_shifter_if.slave  word_bus,
    output logic                ccff_head_o,
    output logic                prog_clk_en_o,
    output logic                pReset_o,
    output logic                fpga_rst_o,
    output logic                busy_o,
    output logic                done_o
);

    localparam int BCNT_W = $clog2(CHAIN_LEN + 1);
    // One extra value so the counter can hold WORD_W itself ("word exhausted").
    localparam int WCNT_W = $clog2(WORD_W + 1);
    localparam int RCNT_W = (PRESET_CYCLES > 1) ? $clog2(PRESET_CYCLES) : 1;

    localparam logic [BCNT_W-1:0] BCNT_MAX  = BCNT_W'(CHAIN_LEN);
    localparam logic [WCNT_W-1:0] WCNT_MAX  = WCNT_W'(WORD_W);
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(PRESET_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RESET = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_r;
    state_t              next_state_s;
    logic [RCNT_W-1:0]   rcnt_r;
    logic [BCNT_W-1:0]   bcnt_r;
    logic [WCNT_W-1:0]   wcnt_r;
    logic [WORD_W-1:0]   sreg_r;
    logic                ccff_r;
    logic                en_r;
    logic                preset_r;
    logic                frst_r;
    logic                busy_r;
    logic                done_r;

    logic                word_ready_s;
    logic                shift_bit_s;
    logic                accept_s;
    logic                busy_nxt_s;
    logic                done_nxt_s;
    logic                en_nxt_s;
    logic                ccff_nxt_s;

    // Handshake and bit-emission decode from state and counters only (no path from valid).
    always_comb begin
        word_ready_s = 1'b0;
        shift_bit_s  = 1'b0;
        case (state_r)
            ST_LOAD: begin
                word_ready_s = 1'b1;
            end
            ST_SHIFT: begin
                // The final-bit check wins, so no word is requested once the chain is full.
                if (bcnt_r < BCNT_MAX) begin
                    if (wcnt_r == WCNT_MAX) begin
                        word_ready_s = 1'b1;
                    end else begin
                        shift_bit_s = 1'b1;
                    end
                end else begin
                    word_ready_s = 1'b0;
                    shift_bit_s  = 1'b0;
                end
            end
            default: begin
                word_ready_s = 1'b0;
                shift_bit_s  = 1'b0;
            end
        endcase
    end

    assign accept_s              = word_ready_s & word_bus.word_valid_i;
    assign word_bus.word_ready_o = word_ready_s;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) next_state_s = ST_RESET;
                else         next_state_s = ST_IDLE;
            end
            ST_RESET: begin
                if (rcnt_r == RCNT_LAST) next_state_s = ST_LOAD;
                else                     next_state_s = ST_RESET;
            end
            ST_LOAD: begin
                if (accept_s) next_state_s = ST_SHIFT;
                else          next_state_s = ST_LOAD;
            end
            ST_SHIFT: begin
                if (bcnt_r == BCNT_MAX) begin
                    next_state_s = ST_DONE;
                end else if (word_ready_s && !accept_s) begin
                    next_state_s = ST_LOAD;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_DONE: begin
                if (start_i) next_state_s = ST_RESET;
                else         next_state_s = ST_DONE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (next_state_s)
            ST_RESET, ST_LOAD, ST_SHIFT: busy_nxt_s = 1'b1;
            ST_DONE:                     done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
        // A freshly accepted word supplies its MSB directly; otherwise the shift register does.
        if (accept_s) begin
            en_nxt_s   = 1'b1;
            ccff_nxt_s = word_bus.word_i[WORD_W-1];
        end else if (shift_bit_s) begin
            en_nxt_s   = 1'b1;
            ccff_nxt_s = sreg_r[WORD_W-1];
        end else begin
            en_nxt_s   = 1'b0;
            ccff_nxt_s = ccff_r;
        end
    end

    // Reset-hold counter, bit/word counters and the word shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rcnt_r <= '0;
            bcnt_r <= '0;
            wcnt_r <= '0;
            sreg_r <= '0;
        end else begin
            if (state_r == ST_RESET) rcnt_r <= rcnt_r + RCNT_W'(1);
            else                     rcnt_r <= '0;

            if (state_r == ST_IDLE || state_r == ST_RESET) begin
                bcnt_r <= '0;
                wcnt_r <= '0;
            end else if (accept_s) begin
                bcnt_r <= bcnt_r + BCNT_W'(1);
                wcnt_r <= WCNT_W'(1);
                sreg_r <= word_bus.word_i << 1;
            end else if (shift_bit_s) begin
                bcnt_r <= bcnt_r + BCNT_W'(1);
                wcnt_r <= wcnt_r + WCNT_W'(1);
                sreg_r <= sreg_r << 1;
            end else begin
                bcnt_r <= bcnt_r;
                wcnt_r <= wcnt_r;
                sreg_r <= sreg_r;
            end
        end
    end

    // Registered outputs; both resets span exactly the busy window.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ccff_r   <= 1'b0;
            en_r     <= 1'b0;
            preset_r <= 1'b0;
            frst_r   <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            ccff_r   <= ccff_nxt_s;
            en_r     <= en_nxt_s;
            preset_r <= busy_nxt_s;
            frst_r   <= busy_nxt_s;
            busy_r   <= busy_nxt_s;
            done_r   <= done_nxt_s;
        end
    end

    assign ccff_head_o   = ccff_r;
    assign prog_clk_en_o = en_r;
    assign pReset_o      = preset_r;
    assign fpga_rst_o    = frst_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;

endmodule
